// File: rtl/drain_pkg.sv
// -----------------------------------------------------------------------------
// drain_pkg
// Shared definitions for the capture-FIFO UART drain: entry geometry, the
// default bit period (27 MHz / 115200 baud) and the FSM state encodings used
// by fifo_uart_drain and its byte serialiser uart_tx_byte.
// -----------------------------------------------------------------------------
package drain_pkg;

    localparam int unsigned ENTRY_W          = 24;
    localparam int unsigned BYTES_PER_ENTRY  = 3;
    localparam int unsigned DEF_CLKS_PER_BIT = 234;

    // Top-level entry sequencer
    typedef enum logic [1:0] {
        IDLE,
        POP,
        LOAD,
        SEND
    } drain_state_e;

    // 8N1 byte serialiser
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser: one start bit (0), eight data bits LSB first, one stop bit
// (1), each lasting CLKS_PER_BIT clocks. The line idles high.
//
// Ports
//   clk     in   system clock, posedge
//   nreset  in   asynchronous active-low reset (tx forced high)
//   start   in   begin a byte; honoured when idle or in the last stop-bit cycle
//   data    in   byte to send, captured with start
//   tx      out  registered serial line
//   done    out  one-cycle pulse during the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
    import drain_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       data_q,  data_d;
    logic             tx_q,    tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        done    = 1'b0;

        if (state_q != TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = TX_START;
                    data_d  = data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    tx_d    = data_q[0];
                end
            end
            TX_DATA: begin
                // data_q shifts right so the next bit is always at [1]
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = data_q[1];
                        data_d = {1'b0, data_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    // A start in this cycle chains the next byte with no gap
                    if (start) begin
                        state_d = TX_START;
                        data_d  = data;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain
// Sole reader of the 24-bit capture FIFO. Whenever the FIFO is non-empty it
// pops one entry and sends it as three 8N1 bytes, MSB byte first.
//
// Ports
//   nreset   in   asynchronous active-low reset
//   clk      in   system clock, posedge
//   empty    in   FIFO empty flag, sampled only while idle
//   pop_dt   in   FIFO read data, valid the cycle after pop_s
//   pop_s    out  one-cycle pop strobe per entry
//   uart_tx  out  serial line, idles high
//   busy     out  high from the pop decision through the last stop bit
// -----------------------------------------------------------------------------
module fifo_uart_drain
    import drain_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic               nreset,
    input  logic               clk,
    input  logic               empty,
    input  logic [ENTRY_W-1:0] pop_dt,
    output logic               pop_s,
    output logic               uart_tx,
    output logic               busy
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_ENTRY - 1);

    drain_state_e       state_q, state_d;
    logic               pop_q,   pop_d;
    logic               busy_q,  busy_d;
    logic [ENTRY_W-1:0] shift_q, shift_d;
    logic [1:0]         idx_q,   idx_d;

    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done;

    assign pop_s = pop_q;
    assign busy  = busy_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .nreset(nreset),
        .start (tx_start),
        .data  (tx_data),
        .tx    (uart_tx),
        .done  (tx_done)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop_d    = 1'b0;
        busy_d   = busy_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tx_start = 1'b0;
        tx_data  = shift_q[ENTRY_W-1 -: 8];

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = POP;
                    pop_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // The first byte goes straight from pop_dt so its start bit
                // begins on this edge; the register holds the entry rotated
                // left by one byte, leaving the next byte on top.
                shift_d  = {pop_dt[ENTRY_W-9:0], pop_dt[ENTRY_W-1 -: 8]};
                idx_d    = '0;
                tx_start = 1'b1;
                tx_data  = pop_dt[ENTRY_W-1 -: 8];
                state_d  = SEND;
            end
            SEND: begin
                if (tx_done) begin
                    if (idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        tx_start = 1'b1;
                        shift_d  = {shift_q[ENTRY_W-9:0], shift_q[ENTRY_W-1 -: 8]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
